// File: rtl/hs_fifo_pkg.sv
// rtl/hs_fifo_pkg.sv - shared types and sizing helpers for the hs_fifo read side
package hs_fifo_pkg;

  typedef enum logic {
    FALSE = 1'b0,
    TRUE  = 1'b1
  } bool_e;

  // Read data appears one cycle after rd_en, or two with the FIFO output register.
  function automatic int rd_latency(bool_e en_output_reg);
    return (en_output_reg == TRUE) ? 2 : 1;
  endfunction

  function automatic int skid_depth(int lat);
    return lat + 2;
  endfunction

endpackage

// File: rtl/hs_fifo_rd_skid_buf.sv
// rtl/hs_fifo_rd_skid_buf.sv - circular data+last buffer with push, pop, flush and occupancy
module hs_fifo_rd_skid_buf
  import hs_fifo_pkg::*;
#(
  parameter type DATA_TYPE = logic [15:0],
  parameter int  DEPTH     = 3,
  localparam int OCC_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  DATA_TYPE         push_data_i,
  input  logic             push_last_i,
  input  logic             pop_i,
  output DATA_TYPE         head_data_o,
  output logic             head_last_o,
  output logic [OCC_W-1:0] occ_o
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  DATA_TYPE         mem_data_q [DEPTH];
  DATA_TYPE         mem_data_d [DEPTH];
  logic [DEPTH-1:0] mem_last_q, mem_last_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  always_comb begin
    mem_data_d = mem_data_q;
    mem_last_d = mem_last_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push_i) begin
        mem_data_d[wr_ptr_q] = push_data_i;
        mem_last_d[wr_ptr_q] = push_last_i;
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   occ_d = occ_q + 1'b1;
        2'b01:   occ_d = occ_q - 1'b1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_q[i] <= '0;
      end
      mem_last_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
    end else begin
      mem_data_q <= mem_data_d;
      mem_last_q <= mem_last_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
    end
  end

  assign head_data_o = mem_data_q[rd_ptr_q];
  assign head_last_o = mem_last_q[rd_ptr_q];
  assign occ_o       = occ_q;

  // The upstream credit scheme guarantees a free slot for every returning word.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && !flush_i && occ_q == FULL_OCC));

endmodule

// File: rtl/hs_fifo_rd_stream_adapter.sv
// rtl/hs_fifo_rd_stream_adapter.sv - FIFO read port to valid/ready stream master with credits and flush
module hs_fifo_rd_stream_adapter
  import hs_fifo_pkg::*;
#(
  parameter type   DATA_TYPE      = logic [15:0],
  parameter bool_e EN_LAST_SIGNAL = FALSE,
  parameter bool_e EN_OUTPUT_REG  = FALSE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        fifo_empty_i,
  output logic        fifo_rd_en_o,
  input  DATA_TYPE    fifo_rd_data_i,
  input  logic        fifo_rd_last_i,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output DATA_TYPE    m_data_o,
  output logic        m_last_o,
  output logic [31:0] beat_cnt_o
);

  localparam int          L     = rd_latency(EN_OUTPUT_REG);
  localparam int          D     = skid_depth(L);
  localparam int          CW    = $clog2(D + 1);
  localparam logic [CW:0] D_LIM = (CW + 1)'(D);

  logic [L-1:0]  rd_pipe_q, rd_pipe_d;
  logic [CW-1:0] infl_q, infl_d;
  logic [31:0]   beat_cnt_q, beat_cnt_d;
  logic [CW-1:0] occ;
  logic [CW:0]   credit_used;
  logic          issue, ret, pop, push_last, head_last;

  // Credits use registered occupancy only, so m_ready_i never reaches fifo_rd_en_o.
  always_comb begin
    credit_used = {1'b0, occ} + {1'b0, infl_q};
    issue       = !fifo_empty_i && !flush_i && (credit_used < D_LIM);
    ret         = rd_pipe_q[L-1];
    pop         = m_valid_o && m_ready_i && !flush_i;
    push_last   = (EN_LAST_SIGNAL == TRUE) ? fifo_rd_last_i : 1'b0;
    rd_pipe_d   = L'({rd_pipe_q, issue});
    infl_d      = infl_q + CW'(issue) - CW'(ret);
    beat_cnt_d  = beat_cnt_q + 32'(pop);
    if (flush_i) begin
      rd_pipe_d = '0;
      infl_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe_q  <= '0;
      infl_q     <= '0;
      beat_cnt_q <= '0;
    end else begin
      rd_pipe_q  <= rd_pipe_d;
      infl_q     <= infl_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  hs_fifo_rd_skid_buf #(
    .DATA_TYPE (DATA_TYPE),
    .DEPTH     (D)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .push_i      (ret),
    .push_data_i (fifo_rd_data_i),
    .push_last_i (push_last),
    .pop_i       (pop),
    .head_data_o (m_data_o),
    .head_last_o (head_last),
    .occ_o       (occ)
  );

  assign fifo_rd_en_o = issue;
  assign m_valid_o    = (occ != '0);
  assign m_last_o     = (EN_LAST_SIGNAL == TRUE) ? head_last : 1'b0;
  assign beat_cnt_o   = beat_cnt_q;

endmodule

// File: tb/tb_hs_fifo_rd_stream_adapter.sv
// tb/tb_hs_fifo_rd_stream_adapter.sv - self-checking bench: L=1 (no last) and L=2 (last) adapters
module tb_hs_fifo_rd_stream_adapter;
  import hs_fifo_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush      [2];
  logic        fifo_empty [2];
  logic        rd_en      [2];
  logic [15:0] rd_data    [2];
  logic        rd_last    [2];
  logic        m_valid    [2];
  logic        m_ready    [2];
  logic [15:0] m_data     [2];
  logic        m_last     [2];
  logic [31:0] beat_cnt   [2];

  // FIFO contents {last,data} and the expected stream in write order
  logic [16:0] fmem   [2][256];
  logic [16:0] refm   [2][256];
  logic [7:0]  wr_ptr [2] = '{8'd0, 8'd0};
  logic [7:0]  rd_ptr [2] = '{8'd0, 8'd0};
  logic [7:0]  exp_rd [2] = '{8'd0, 8'd0};
  logic [16:0] s1     [2] = '{17'd0, 17'd0};
  logic [16:0] s2         = 17'd0;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rd_en[d]) begin
        s1[d]     <= fmem[d][rd_ptr[d]];
        rd_ptr[d] <= rd_ptr[d] + 8'd1;
      end
    end
    s2 <= s1[1];
  end

  assign fifo_empty[0] = (wr_ptr[0] == rd_ptr[0]);
  assign fifo_empty[1] = (wr_ptr[1] == rd_ptr[1]);
  assign rd_data[0]    = s1[0][15:0];
  assign rd_last[0]    = s1[0][16];
  assign rd_data[1]    = s2[15:0];
  assign rd_last[1]    = s2[16];

  hs_fifo_rd_stream_adapter #(
    .DATA_TYPE      (logic [15:0]),
    .EN_LAST_SIGNAL (FALSE),
    .EN_OUTPUT_REG  (FALSE)
  ) u_dut_l1 (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush[0]),
    .fifo_empty_i   (fifo_empty[0]),
    .fifo_rd_en_o   (rd_en[0]),
    .fifo_rd_data_i (rd_data[0]),
    .fifo_rd_last_i (rd_last[0]),
    .m_valid_o      (m_valid[0]),
    .m_ready_i      (m_ready[0]),
    .m_data_o       (m_data[0]),
    .m_last_o       (m_last[0]),
    .beat_cnt_o     (beat_cnt[0])
  );

  hs_fifo_rd_stream_adapter #(
    .DATA_TYPE      (logic [15:0]),
    .EN_LAST_SIGNAL (TRUE),
    .EN_OUTPUT_REG  (TRUE)
  ) u_dut_l2 (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush[1]),
    .fifo_empty_i   (fifo_empty[1]),
    .fifo_rd_en_o   (rd_en[1]),
    .fifo_rd_data_i (rd_data[1]),
    .fifo_rd_last_i (rd_last[1]),
    .m_valid_o      (m_valid[1]),
    .m_ready_i      (m_ready[1]),
    .m_data_o       (m_data[1]),
    .m_last_o       (m_last[1]),
    .beat_cnt_o     (beat_cnt[1])
  );

  task automatic push_word(input int d, input logic [15:0] w, input logic lst);
    fmem[d][wr_ptr[d]] = {lst, w};
    refm[d][wr_ptr[d]] = {(d == 1) ? lst : 1'b0, w};
    wr_ptr[d] = wr_ptr[d] + 8'd1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_total++;
      if (m_valid[d] !== 1'b0) $display("FAIL reset_valid[%0d]: got %b expected 0", d, m_valid[d]);
      else n_pass++;
      n_total++;
      if (m_data[d] !== 16'h0) $display("FAIL reset_data[%0d]: got %h expected 0000", d, m_data[d]);
      else n_pass++;
      n_total++;
      if (m_last[d] !== 1'b0) $display("FAIL reset_last[%0d]: got %b expected 0", d, m_last[d]);
      else n_pass++;
      n_total++;
      if (beat_cnt[d] !== 32'd0) $display("FAIL reset_cnt[%0d]: got %0d expected 0", d, beat_cnt[d]);
      else n_pass++;
      n_total++;
      if (rd_en[d] !== 1'b0) $display("FAIL reset_rd_en[%0d]: got %b expected 0", d, rd_en[d]);
      else n_pass++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stream(input int d);
    int          t_rd, t_val, beats, bubbles;
    logic [31:0] cnt0;
    logic [16:0] e;
    m_ready[d] = 1'b1;
    cnt0 = beat_cnt[d];
    for (int i = 1; i <= 8; i++) push_word(d, 16'(i), 1'b0);
    t_rd = -1; t_val = -1; beats = 0; bubbles = 0;
    for (int k = 0; k < 40 && beats < 8; k++) begin
      #1;
      if (rd_en[d] && t_rd < 0) t_rd = k;
      if (m_valid[d]) begin
        if (t_val < 0) t_val = k;
        e = refm[d][exp_rd[d]];
        n_total++;
        if (m_data[d] !== e[15:0]) $display("FAIL stream_data[%0d] beat %0d: got %h expected %h", d, beats, m_data[d], e[15:0]);
        else n_pass++;
        exp_rd[d] = exp_rd[d] + 8'd1;
        beats++;
      end else if (t_val >= 0) begin
        bubbles++;
      end
      @(negedge clk);
    end
    #1;
    n_total++;
    if (t_val - t_rd !== d + 2) $display("FAIL stream_latency[%0d]: got %0d expected %0d", d, t_val - t_rd, d + 2);
    else n_pass++;
    n_total++;
    if (bubbles !== 0) $display("FAIL stream_bubbles[%0d]: got %0d expected 0", d, bubbles);
    else n_pass++;
    n_total++;
    if (beat_cnt[d] !== cnt0 + 32'd8) $display("FAIL stream_cnt[%0d]: got %0d expected %0d", d, beat_cnt[d], cnt0 + 32'd8);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_backpressure(input int d);
    int          reads, beats, changed;
    logic        have;
    logic [15:0] hold;
    logic [31:0] cnt0;
    logic [16:0] e;
    m_ready[d] = 1'b0;
    cnt0 = beat_cnt[d];
    for (int i = 0; i < 10; i++) push_word(d, 16'($urandom), 1'b0);
    reads = 0; changed = 0; have = 1'b0; hold = 16'h0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (rd_en[d]) reads++;
      if (m_valid[d]) begin
        if (!have) begin
          have = 1'b1;
          hold = m_data[d];
        end else if (m_data[d] !== hold) begin
          changed++;
        end
      end
      @(negedge clk);
    end
    n_total++;
    if (reads !== d + 3) $display("FAIL bp_reads[%0d]: got %0d expected %0d", d, reads, d + 3);
    else n_pass++;
    n_total++;
    if (have !== 1'b1 || changed !== 0) $display("FAIL bp_hold[%0d]: got valid_seen=%b changes=%0d expected 1 and 0", d, have, changed);
    else n_pass++;
    m_ready[d] = 1'b1;
    beats = 0;
    for (int k = 0; k < 60 && beats < 10; k++) begin
      #1;
      if (m_valid[d]) begin
        e = refm[d][exp_rd[d]];
        n_total++;
        if (m_data[d] !== e[15:0]) $display("FAIL bp_data[%0d] beat %0d: got %h expected %h", d, beats, m_data[d], e[15:0]);
        else n_pass++;
        exp_rd[d] = exp_rd[d] + 8'd1;
        beats++;
      end
      @(negedge clk);
    end
    #1;
    n_total++;
    if (beat_cnt[d] !== cnt0 + 32'd10) $display("FAIL bp_cnt[%0d]: got %0d expected %0d", d, beat_cnt[d], cnt0 + 32'd10);
    else n_pass++;
    n_total++;
    if (m_valid[d] !== 1'b0) $display("FAIL bp_no_extra[%0d]: got %b expected 0", d, m_valid[d]);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_last(input int d);
    int          beats;
    logic        exp_l;
    logic [16:0] e;
    m_ready[d] = 1'b1;
    for (int i = 0; i < 4; i++) push_word(d, 16'h0C00 + 16'(i), (i == 3));
    beats = 0;
    for (int k = 0; k < 20 && beats < 4; k++) begin
      #1;
      if (m_valid[d]) begin
        e = refm[d][exp_rd[d]];
        exp_l = (d == 1) && (beats == 3);
        n_total++;
        if (m_last[d] !== exp_l || m_data[d] !== e[15:0])
          $display("FAIL last[%0d] beat %0d: got last=%b data=%h expected last=%b data=%h", d, beats, m_last[d], m_data[d], exp_l, e[15:0]);
        else n_pass++;
        exp_rd[d] = exp_rd[d] + 8'd1;
        beats++;
      end
      @(negedge clk);
    end
    n_total++;
    if (beats !== 4) $display("FAIL last_beats[%0d]: got %0d expected 4", d, beats);
    else n_pass++;
  endtask

  task automatic test_random(input int d);
    int          beats;
    logic        prev_stall, prev_last;
    logic [15:0] prev_data;
    logic [31:0] cnt0;
    logic [16:0] e;
    cnt0 = beat_cnt[d];
    for (int i = 0; i < 24; i++) push_word(d, 16'($urandom), 1'($urandom));
    beats = 0; prev_stall = 1'b0; prev_last = 1'b0; prev_data = 16'h0;
    for (int k = 0; k < 400 && beats < 24; k++) begin
      m_ready[d] = 1'($urandom);
      #1;
      if (prev_stall) begin
        n_total++;
        if ({m_valid[d], m_last[d], m_data[d]} !== {1'b1, prev_last, prev_data})
          $display("FAIL rand_hold[%0d]: got v=%b l=%b d=%h expected v=1 l=%b d=%h", d, m_valid[d], m_last[d], m_data[d], prev_last, prev_data);
        else n_pass++;
      end
      if (m_valid[d] && m_ready[d]) begin
        e = refm[d][exp_rd[d]];
        n_total++;
        if ({m_last[d], m_data[d]} !== e)
          $display("FAIL rand_beat[%0d] %0d: got l=%b d=%h expected l=%b d=%h", d, beats, m_last[d], m_data[d], e[16], e[15:0]);
        else n_pass++;
        exp_rd[d] = exp_rd[d] + 8'd1;
        beats++;
      end
      prev_stall = m_valid[d] && !m_ready[d];
      prev_last  = m_last[d];
      prev_data  = m_data[d];
      @(negedge clk);
    end
    m_ready[d] = 1'b0;
    #1;
    n_total++;
    if (beats !== 24 || beat_cnt[d] !== cnt0 + 32'd24)
      $display("FAIL rand_cnt[%0d]: got beats=%0d cnt=%0d expected 24 and %0d", d, beats, beat_cnt[d], cnt0 + 32'd24);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_flush();
    int          beats;
    logic [31:0] cnt0;
    logic [16:0] e;
    // L=2: flush one cycle after the read of the first word
    m_ready[1] = 1'b1;
    cnt0 = beat_cnt[1];
    push_word(1, 16'hA1A1, 1'b0);
    push_word(1, 16'hB2B2, 1'b0);
    push_word(1, 16'hC3C3, 1'b0);
    #1;
    n_total++;
    if (rd_en[1] !== 1'b1) $display("FAIL flush_first_read: got %b expected 1", rd_en[1]);
    else n_pass++;
    @(negedge clk);
    flush[1] = 1'b1;
    #1;
    n_total++;
    if (rd_en[1] !== 1'b0) $display("FAIL flush_rd_gated: got %b expected 0", rd_en[1]);
    else n_pass++;
    @(negedge clk);
    flush[1] = 1'b0;
    #1;
    n_total++;
    if (m_valid[1] !== 1'b0) $display("FAIL flush_valid_l2: got %b expected 0", m_valid[1]);
    else n_pass++;
    exp_rd[1] = exp_rd[1] + 8'd1;
    @(negedge clk);
    beats = 0;
    for (int k = 0; k < 20 && beats < 2; k++) begin
      #1;
      if (m_valid[1]) begin
        e = refm[1][exp_rd[1]];
        n_total++;
        if (m_data[1] !== e[15:0]) $display("FAIL flush_after_l2 beat %0d: got %h expected %h", beats, m_data[1], e[15:0]);
        else n_pass++;
        exp_rd[1] = exp_rd[1] + 8'd1;
        beats++;
      end
      @(negedge clk);
    end
    #1;
    n_total++;
    if (beat_cnt[1] !== cnt0 + 32'd2) $display("FAIL flush_cnt_l2: got %0d expected %0d", beat_cnt[1], cnt0 + 32'd2);
    else n_pass++;
    @(negedge clk);

    // L=1: flush a full buffer with a handshake in the flush cycle
    m_ready[0] = 1'b0;
    cnt0 = beat_cnt[0];
    for (int i = 0; i < 5; i++) push_word(0, 16'($urandom), 1'b0);
    repeat (6) @(negedge clk);
    #1;
    n_total++;
    if (m_valid[0] !== 1'b1) $display("FAIL flush_pre_valid: got %b expected 1", m_valid[0]);
    else n_pass++;
    m_ready[0] = 1'b1;
    flush[0]   = 1'b1;
    @(negedge clk);
    flush[0]   = 1'b0;
    m_ready[0] = 1'b0;
    #1;
    n_total++;
    if (m_valid[0] !== 1'b0 || beat_cnt[0] !== cnt0)
      $display("FAIL flush_l1: got valid=%b cnt=%0d expected 0 and %0d", m_valid[0], beat_cnt[0], cnt0);
    else n_pass++;
    exp_rd[0] = exp_rd[0] + 8'd3;
    @(negedge clk);
    m_ready[0] = 1'b1;
    beats = 0;
    for (int k = 0; k < 20 && beats < 2; k++) begin
      #1;
      if (m_valid[0]) begin
        e = refm[0][exp_rd[0]];
        n_total++;
        if (m_data[0] !== e[15:0]) $display("FAIL flush_after_l1 beat %0d: got %h expected %h", beats, m_data[0], e[15:0]);
        else n_pass++;
        exp_rd[0] = exp_rd[0] + 8'd1;
        beats++;
      end
      @(negedge clk);
    end
    #1;
    n_total++;
    if (beat_cnt[0] !== cnt0 + 32'd2) $display("FAIL flush_cnt_l1: got %0d expected %0d", beat_cnt[0], cnt0 + 32'd2);
    else n_pass++;
    m_ready[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    m_ready[0] = 1'b0;
    m_ready[1] = 1'b0;
    push_word(0, 16'h5A5A, 1'b0);
    push_word(0, 16'h6B6B, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    n_total++;
    if (m_valid[0] !== 1'b1 || m_data[0] !== 16'h5A5A)
      $display("FAIL areset_pre: got valid=%b data=%h expected 1 and 5a5a", m_valid[0], m_data[0]);
    else n_pass++;
    #1;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (m_valid[0] !== 1'b0) $display("FAIL areset_valid: got %b expected 0", m_valid[0]);
    else n_pass++;
    n_total++;
    if (m_data[0] !== 16'h0 || m_last[0] !== 1'b0) $display("FAIL areset_data: got %h/%b expected 0000/0", m_data[0], m_last[0]);
    else n_pass++;
    n_total++;
    if (beat_cnt[0] !== 32'd0 || beat_cnt[1] !== 32'd0)
      $display("FAIL areset_cnt: got %0d/%0d expected 0/0", beat_cnt[0], beat_cnt[1]);
    else n_pass++;
    exp_rd[0] = exp_rd[0] + 8'd2;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_total++;
      if ({m_valid[d], m_last[d], rd_en[d], m_data[d], beat_cnt[d]} !== {3'b000, 16'h0, 32'd0})
        $display("FAIL areset_post[%0d]: got v=%b l=%b rd=%b d=%h cnt=%0d expected all 0", d, m_valid[d], m_last[d], rd_en[d], m_data[d], beat_cnt[d]);
      else n_pass++;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    flush[0]   = 1'b0;
    flush[1]   = 1'b0;
    m_ready[0] = 1'b0;
    m_ready[1] = 1'b0;
    test_reset();
    test_stream(0);
    test_stream(1);
    test_backpressure(0);
    test_backpressure(1);
    test_last(0);
    test_last(1);
    test_random(0);
    test_random(1);
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
